// File: rtl/bf16_pkg.sv
// rtl/bf16_pkg.sv - BF16 format constants, operand struct and classification helpers
package bf16_pkg;

  localparam int E    = 8;
  localparam int M    = 7;
  localparam int BIAS = (1 << (E - 1)) - 1;

  typedef struct packed {
    logic         s;
    logic [E-1:0] e;
    logic [M-1:0] m;
  } bf16_t;

  localparam logic [E-1:0] EXP_MAX = {E{1'b1}};
  localparam logic [M-1:0] NAN_MAN = {M{1'b1}};

  function automatic logic is_zero(bf16_t x);
    return (x.e == '0) && (x.m == '0);
  endfunction

  function automatic logic is_inf(bf16_t x);
    return (x.e == EXP_MAX) && (x.m == '0);
  endfunction

  function automatic logic is_nan(bf16_t x);
    return (x.e == EXP_MAX) && (x.m != '0);
  endfunction

endpackage

// File: rtl/bf16_lzc.sv
// rtl/bf16_lzc.sv - leading-zero counter giving the left-normalisation shift amount
module bf16_lzc #(
  parameter int W  = 11,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] cnt
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (vec[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/bf16_add.sv
// rtl/bf16_add.sv - registered BF16 adder with RNE rounding; BF16_ADD_SUBNORMAL_EN enables subnormals (default flush-to-zero)
module bf16_add #(
  parameter int E = 8,
  parameter int M = 7
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         sa_i,
  input  logic [E-1:0] ea_i,
  input  logic [M-1:0] ma_i,
  input  logic         sb_i,
  input  logic [E-1:0] eb_i,
  input  logic [M-1:0] mb_i,
  output logic         s_o,
  output logic [E-1:0] e_o,
  output logic [M-1:0] m_o
);

  import bf16_pkg::*;

  // Normalisation vector: hidden bit, M mantissa bits, guard, round, sticky.
  localparam int W  = M + 4;
  localparam int CW = $clog2(W + 1);
  // Working exponent width: room for carry-out and rounding overflow past all-ones.
  localparam int XW = E + 2;

  bf16_t op_a, op_b;
  assign op_a = {sa_i, ea_i, ma_i};
  assign op_b = {sb_i, eb_i, mb_i};

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  assign a_nan = is_nan(op_a);
  assign b_nan = is_nan(op_b);
  assign a_inf = is_inf(op_a);
  assign b_inf = is_inf(op_b);
`ifdef BF16_ADD_SUBNORMAL_EN
  assign a_zero = is_zero(op_a);
  assign b_zero = is_zero(op_b);
`else
  // Flush-to-zero: any e==0 operand counts as a signed zero.
  assign a_zero = (ea_i == '0);
  assign b_zero = (eb_i == '0);
`endif

  // Subnormals sit at effective exponent 1 with a zero hidden bit.
  logic [E-1:0] ea_eff, eb_eff;
  logic [M:0]   ma_full, mb_full;
  assign ea_eff  = (ea_i == '0) ? E'(1) : ea_i;
  assign eb_eff  = (eb_i == '0) ? E'(1) : eb_i;
  assign ma_full = {(ea_i != '0), ma_i};
  assign mb_full = {(eb_i != '0), mb_i};

  logic         a_ge;
  logic         big_s;
  logic [E-1:0] big_e, sml_e, diff;
  logic [M:0]   big_m, sml_m;
  assign a_ge = {ea_i, ma_i} >= {eb_i, mb_i};

  // Order operands by magnitude so the subtraction below never goes negative.
  always_comb begin
    if (a_ge) begin
      big_s = sa_i;   big_e = ea_eff; big_m = ma_full;
      sml_e = eb_eff; sml_m = mb_full;
    end else begin
      big_s = sb_i;   big_e = eb_eff; big_m = mb_full;
      sml_e = ea_eff; sml_m = ma_full;
    end
  end

  assign diff = big_e - sml_e;

  logic [W-1:0]  sml_x, aligned;
  logic [CW-1:0] sh;
  assign sml_x = {sml_m, 3'b000};
  assign sh    = diff[CW-1:0];

  // Align the smaller operand, folding every bit shifted out into the sticky position.
  always_comb begin
    if (diff >= E'(W)) begin
      aligned = {{(W-1){1'b0}}, |sml_m};
    end else begin
      aligned = (sml_x >> sh) | {{(W-1){1'b0}}, |(sml_x & ~({W{1'b1}} << sh))};
    end
  end

  logic         eff_sub;
  logic [W:0]   big_x, al_x, sum;
  assign eff_sub = sa_i ^ sb_i;
  assign big_x   = {1'b0, big_m, 3'b000};
  assign al_x    = {1'b0, aligned};
  assign sum     = eff_sub ? (big_x - al_x) : (big_x + al_x);

  logic [CW-1:0] lz;
  bf16_lzc #(.W(W), .CW(CW)) u_lzc (
    .vec (sum[W-1:0]),
    .cnt (lz)
  );

  logic [XW-1:0] exp_big, lz_x, exp_n;
  logic [W-1:0]  norm;
  logic          tiny;
  assign exp_big = {2'b00, big_e};
  assign lz_x    = {{(XW-CW){1'b0}}, lz};

  // Normalise: carry-out shifts right with sticky merge, otherwise shift left by the zero count.
  always_comb begin
    norm  = '0;
    exp_n = '0;
    tiny  = 1'b0;
    if (sum[W]) begin
      norm  = {sum[W:2], sum[1] | sum[0]};
      exp_n = exp_big + XW'(1);
    end else if (lz_x >= exp_big) begin
      // Normalised exponent would drop below 1.
      tiny = 1'b1;
`ifdef BF16_ADD_SUBNORMAL_EN
      // Shift only up to exponent 1; the result leaves with e=0 unless rounding restores the hidden bit.
      norm = sum[W-1:0] << (big_e[CW-1:0] - 1'b1);
`endif
    end else begin
      norm  = sum[W-1:0] << lz;
      exp_n = exp_big - lz_x;
    end
  end

  logic          inc;
  logic [M+1:0]  rnd;
  logic [XW-1:0] exp_r;
  logic [M-1:0]  man_r;
  assign inc = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign rnd = {1'b0, norm[W-1:3]} + {{(M+1){1'b0}}, inc};

  // Round to nearest even; a rounding carry bumps the exponent.
  always_comb begin
    if (tiny) begin
      exp_r = {{(XW-1){1'b0}}, rnd[M]};
      man_r = rnd[M-1:0];
    end else if (rnd[M+1]) begin
      exp_r = exp_n + XW'(1);
      man_r = rnd[M:1];
    end else begin
      exp_r = exp_n;
      man_r = rnd[M-1:0];
    end
  end

  bf16_t arith, res_d, res_q;

  // Pack the arithmetic result: cancellation, underflow and overflow handling.
  always_comb begin
    if (sum == '0) begin
      arith = '0;
    end else if (tiny) begin
`ifdef BF16_ADD_SUBNORMAL_EN
      arith = {big_s, exp_r[E-1:0], man_r};
`else
      arith = {big_s, {E{1'b0}}, {M{1'b0}}};
`endif
    end else if (exp_r >= {2'b00, EXP_MAX}) begin
      arith = {big_s, EXP_MAX, {M{1'b0}}};
    end else begin
      arith = {big_s, exp_r[E-1:0], man_r};
    end
  end

  // Special-value priority mux ahead of the arithmetic result.
  always_comb begin
    res_d = arith;
    if (a_nan) begin
      res_d = {sa_i, EXP_MAX, NAN_MAN};
    end else if (b_nan) begin
      res_d = {sb_i, EXP_MAX, NAN_MAN};
    end else if (a_inf && b_inf && (sa_i != sb_i)) begin
      res_d = {1'b0, EXP_MAX, NAN_MAN};
    end else if (a_inf) begin
      res_d = op_a;
    end else if (b_inf) begin
      res_d = op_b;
    end else if (a_zero && b_zero) begin
      res_d = {sa_i & sb_i, {E{1'b0}}, {M{1'b0}}};
    end else if (a_zero) begin
      res_d = op_b;
    end else if (b_zero) begin
      res_d = op_a;
    end
  end

  // Single output register; reset forces +0 immediately.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) res_q <= '0;
    else         res_q <= res_d;
  end

  assign s_o = res_q.s;
  assign e_o = res_q.e;
  assign m_o = res_q.m;

endmodule

// File: tb/tb_bf16_add.sv
// tb/tb_bf16_add.sv - self-checking bench for bf16_add against a real-arithmetic reference
module tb_bf16_add;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       sa = 1'b0, sb = 1'b0, so;
  logic [7:0] ea = '0, eb = '0, eo;
  logic [6:0] ma = '0, mb = '0, mo;
  logic [15:0] got;
  int checks = 0;
  int failures = 0;

  assign got = {so, eo, mo};

  bf16_add dut (
    .clk    (clk),
    .nreset (nreset),
    .sa_i   (sa),
    .ea_i   (ea),
    .ma_i   (ma),
    .sb_i   (sb),
    .eb_i   (eb),
    .mb_i   (mb),
    .s_o    (so),
    .e_o    (eo),
    .m_o    (mo)
  );

  always #5 clk = ~clk;

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else repeat (-n) r = r / 2.0;
    return r;
  endfunction

  function automatic real to_real(input logic [15:0] x);
    real v;
    if (x[14:7] == 8'h00) begin
`ifdef BF16_ADD_SUBNORMAL_EN
      v = real'(int'(x[6:0])) * pow2(-133);
`else
      v = 0.0;
`endif
    end else begin
      v = real'(int'({1'b1, x[6:0]})) * pow2(int'(x[14:7]) - 134);
    end
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] round_bf16(input real x);
    logic sg;
    real  ax, q, fl;
    int   ex, be, qi;
    sg = (x < 0.0);
    ax = sg ? -x : x;
    ex = 0;
    while (ax >= pow2(ex + 1)) ex++;
    while (ax < pow2(ex)) ex--;
    be = ex + 127;
    if (be < 1) begin
`ifdef BF16_ADD_SUBNORMAL_EN
      ex = -126;
`else
      return {sg, 15'h0000};
`endif
    end
    q  = ax / pow2(ex - 7);
    fl = $floor(q);
    qi = int'(fl);
    if ((q - fl) > 0.5 || ((q - fl) == 0.5 && qi[0])) qi++;
    if (be < 1) be = (qi >= 128) ? 1 : 0;
    else if (qi == 256) begin
      qi = 128;
      be++;
    end
    if (be >= 255) return {sg, 8'hFF, 7'h00};
    return {sg, 8'(be), 7'(qi)};
  endfunction

  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    real  x;
    a_nan = (a[14:7] == 8'hFF) && (a[6:0] != 0);
    b_nan = (b[14:7] == 8'hFF) && (b[6:0] != 0);
    a_inf = (a[14:7] == 8'hFF) && (a[6:0] == 0);
    b_inf = (b[14:7] == 8'hFF) && (b[6:0] == 0);
`ifdef BF16_ADD_SUBNORMAL_EN
    a_zero = (a[14:0] == 0);
    b_zero = (b[14:0] == 0);
`else
    a_zero = (a[14:7] == 0);
    b_zero = (b[14:7] == 0);
`endif
    if (a_nan) return {a[15], 15'h7FFF};
    if (b_nan) return {b[15], 15'h7FFF};
    if (a_inf && b_inf && (a[15] != b[15])) return 16'h7FFF;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a_zero && b_zero) return {a[15] & b[15], 15'h0000};
    if (a_zero) return b;
    if (b_zero) return a;
    x = to_real(a) + to_real(b);
    if (x == 0.0) return 16'h0000;
    return round_bf16(x);
  endfunction

  function automatic logic [15:0] rnd_op();
    int k;
    logic [7:0] ex;
    k = int'($urandom_range(0, 15));
    if (k == 0) ex = 8'h00;
    else if (k == 1) ex = 8'hFF;
    else ex = 8'($urandom_range(1, 254));
    return {1'($urandom), ex, 7'($urandom)};
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    {sa, ea, ma} = a;
    {sb, eb, mb} = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (got !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state: got %h expected 0000", got);
    end
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_zeros();
    logic [47:0] tbl [6];
    tbl = '{{16'h0000, 16'h0000, 16'h0000},
            {16'h0000, 16'h8000, 16'h0000},
            {16'h8000, 16'h8000, 16'h8000},
            {16'h0000, 16'h3F80, 16'h3F80},
            {16'h8000, 16'hBF80, 16'hBF80},
            {16'h0000, 16'hBF80, 16'hBF80}};
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i][47:32], tbl[i][31:16]);
      checks++;
      if (got !== tbl[i][15:0]) begin
        failures++;
        $display("FAIL zeros[%0d]: got %h expected %h", i, got, tbl[i][15:0]);
      end
    end
  endtask

  task automatic test_nan();
    logic [15:0] b, a, ex;
    for (int i = 0; i < 100; i++) begin
      b = rnd_op();
      drive(16'hFFAA, b);
      checks++;
      if (got !== 16'hFFFF) begin
        failures++;
        $display("FAIL nan_fixed b=%h: got %h expected ffff", b, got);
      end
    end
    for (int i = 0; i < 100; i++) begin
      a  = {1'($urandom), 8'hFF, 7'($urandom_range(1, 127))};
      b  = rnd_op();
      ex = {a[15], 15'h7FFF};
      drive(a, b);
      checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL nan_rand a=%h b=%h: got %h expected %h", a, b, got, ex);
      end
    end
  endtask

  task automatic test_inf();
    logic [47:0] tbl [3];
    tbl = '{{16'h7F80, 16'hFF80, 16'h7FFF},
            {16'h7F80, 16'hC040, 16'h7F80},
            {16'h7F7F, 16'h7F7F, 16'h7F80}};
    for (int i = 0; i < 3; i++) begin
      drive(tbl[i][47:32], tbl[i][31:16]);
      checks++;
      if (got !== tbl[i][15:0]) begin
        failures++;
        $display("FAIL inf[%0d]: got %h expected %h", i, got, tbl[i][15:0]);
      end
    end
  endtask

  task automatic test_arith();
    logic [47:0] tbl [4];
    tbl = '{{16'h3F80, 16'h3F80, 16'h4000},
            {16'h3F80, 16'h3B80, 16'h3F80},
            {16'h3F81, 16'h3B80, 16'h3F82},
            {16'h3F80, 16'hBF80, 16'h0000}};
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i][47:32], tbl[i][31:16]);
      checks++;
      if (got !== tbl[i][15:0]) begin
        failures++;
        $display("FAIL arith[%0d]: got %h expected %h", i, got, tbl[i][15:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, ex;
    int e2;
    for (int i = 0; i < 400; i++) begin
      a = rnd_op();
      case ($urandom_range(0, 3))
        0: b = rnd_op();
        1: begin
          e2 = int'(a[14:7]) + int'($urandom_range(0, 16)) - 8;
          if (e2 < 1) e2 = 1;
          if (e2 > 254) e2 = 254;
          b = {1'($urandom), 8'(e2), 7'($urandom)};
        end
        2: b = {~a[15], a[14:3], 3'($urandom)};
        default: begin
          a = {1'($urandom), 8'($urandom_range(1, 12)), 7'($urandom)};
          b = {1'($urandom), 8'($urandom_range(1, 12)), 7'($urandom)};
        end
      endcase
      ex = model(a, b);
      drive(a, b);
      checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL random a=%h b=%h: got %h expected %h", a, b, got, ex);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] expq [$];
    logic [15:0] a, b, ex;
    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      if (i > 0) begin
        ex = expq.pop_front();
        checks++;
        if (got !== ex) begin
          failures++;
          $display("FAIL back_to_back[%0d]: got %h expected %h", i - 1, got, ex);
        end
      end
      if (i < 40) begin
        a = rnd_op();
        b = {1'($urandom), 8'($urandom_range(100, 140)), 7'($urandom)};
        {sa, ea, ma} = a;
        {sb, eb, mb} = b;
        expq.push_back(model(a, b));
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(16'h3F80, 16'h3F80);
    checks++;
    if (got !== 16'h4000) begin
      failures++;
      $display("FAIL pre_reset_sum: got %h expected 4000", got);
    end
    @(negedge clk);
    {sa, ea, ma} = 16'h3F80;
    {sb, eb, mb} = 16'h3B80;
    @(posedge clk);
    #2;
    nreset = 1'b0;
    #1;
    checks++;
    if (got !== 16'h0000) begin
      failures++;
      $display("FAIL async_reset: got %h expected 0000", got);
    end
    @(posedge clk);
    #1;
    checks++;
    if (got !== 16'h0000) begin
      failures++;
      $display("FAIL reset_hold: got %h expected 0000", got);
    end
    @(negedge clk);
    {sa, ea, ma} = 16'h4000;
    {sb, eb, mb} = 16'h3F80;
    nreset = 1'b1;
    #1;
    checks++;
    if (got !== 16'h0000) begin
      failures++;
      $display("FAIL post_release: got %h expected 0000", got);
    end
    @(posedge clk);
    #1;
    checks++;
    if (got !== 16'h4040) begin
      failures++;
      $display("FAIL first_after_reset: got %h expected 4040", got);
    end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_nan();
    test_inf();
    test_arith();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
